c1_outputs: RTL and testbench

Write-side register bank of the C1 I/O chip: decodes 68K byte writes into the $380000-$39FFFF output zone and drives the controller-port output pins, memory card bank, slot select, marquee/credit LED latches and RTC control lines. The 68K write strobe is asynchronous to the system clock, so the block synchronizes and edge-detects it. Register updates are committed exactly once per write. It sits beside the C1 input multiplexer, which serves reads on the same chip, and drives the board-level pins directly.

---
 rtl/c1_outputs.sv | 171 +++++++++++++++++
 tb/tb_c1_outputs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/c1_outputs.sv
// C1 I/O chip write-side register bank: synchronizes the 68K low-byte write
// strobe, commits one register update per strobe fall and drives board pins.
module c1_outputs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic       nPORTWEL,
  input  logic [2:0] M68K_ADDR,
  input  logic [7:0] M68K_DATA,
  output logic [2:0] P1_OUT,
  output logic [2:0] P2_OUT,
  output logic [2:0] CARD_BANK,
  output logic [2:0] SLOT,
  output logic [7:0] LED_MARQUEE,
  output logic [7:0] LED_CREDIT1,
  output logic [7:0] LED_CREDIT2,
  output logic       RTC_DIN,
  output logic       RTC_CLK,
  output logic       RTC_STB,
  output logic       WR_COMMIT
);

  localparam int unsigned PIN_W  = 3;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned LLC_W  = 3;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] A_POUTPUT    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CRDBANK    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SLOT       = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_LEDLATCHES = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_LEDDATA    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RTCCTRL    = ADDR_W'(5);

  // Strobe synchronizer, edge detector and post-reset arming
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   synced_c;
  logic                   commit_c;

  // Register bank state
  logic [PIN_W-1:0] p1_q, p1_d;
  logic [PIN_W-1:0] p2_q, p2_d;
  logic [PIN_W-1:0] bank_q, bank_d;
  logic [PIN_W-1:0] slot_q, slot_d;
  logic [LED_W-1:0] led_marquee_q, led_marquee_d;
  logic [LED_W-1:0] led_credit1_q, led_credit1_d;
  logic [LED_W-1:0] led_credit2_q, led_credit2_d;
  logic [LED_W-1:0] leddata_q, leddata_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  logic [LLC_W-1:0] llc_fall_c;
  logic             rtc_din_q, rtc_din_d;
  logic             rtc_clk_q, rtc_clk_d;
  logic             rtc_stb_q, rtc_stb_d;
  logic             commit_q, commit_d;

  // vld_q tracks which sync stages hold a real sample rather than a reset
  // value, so a strobe already low at reset release never looks like a fall.
  always_comb begin
    synced_c = sync_q[SYNC_STAGES-1];
    sync_d   = {sync_q[SYNC_STAGES-2:0], nPORTWEL};
    vld_d    = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_d   = synced_c;
    armed_d  = armed_q | (vld_q[SYNC_STAGES-1] & synced_c);
    commit_c = armed_q & prev_q & ~synced_c;
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      sync_q  <= '1;
      vld_q   <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  // Address decode; LED targets latch the LEDDATA value held before this write
  always_comb begin
    p1_d          = p1_q;
    p2_d          = p2_q;
    bank_d        = bank_q;
    slot_d        = slot_q;
    led_marquee_d = led_marquee_q;
    led_credit1_d = led_credit1_q;
    led_credit2_d = led_credit2_q;
    leddata_d     = leddata_q;
    llc_d         = llc_q;
    rtc_din_d     = rtc_din_q;
    rtc_clk_d     = rtc_clk_q;
    rtc_stb_d     = rtc_stb_q;
    commit_d      = commit_c;
    llc_fall_c    = llc_q & ~M68K_DATA[5:3];

    if (commit_c) begin
      case (M68K_ADDR)
        A_POUTPUT: begin
          p1_d = M68K_DATA[2:0];
          p2_d = M68K_DATA[5:3];
        end
        A_CRDBANK: bank_d = M68K_DATA[2:0];
        A_SLOT:    slot_d = M68K_DATA[2:0];
        A_LEDLATCHES: begin
          llc_d = M68K_DATA[5:3];
          if (llc_fall_c[0]) led_marquee_d = leddata_q;
          if (llc_fall_c[1]) led_credit1_d = leddata_q;
          if (llc_fall_c[2]) led_credit2_d = leddata_q;
        end
        A_LEDDATA: leddata_d = M68K_DATA;
        A_RTCCTRL: begin
          rtc_din_d = M68K_DATA[0];
          rtc_clk_d = M68K_DATA[1];
          rtc_stb_d = M68K_DATA[2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      p1_q          <= '0;
      p2_q          <= '0;
      bank_q        <= '0;
      slot_q        <= '0;
      led_marquee_q <= '0;
      led_credit1_q <= '0;
      led_credit2_q <= '0;
      leddata_q     <= '0;
      llc_q         <= '1;
      rtc_din_q     <= 1'b0;
      rtc_clk_q     <= 1'b0;
      rtc_stb_q     <= 1'b0;
      commit_q      <= 1'b0;
    end else begin
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      bank_q        <= bank_d;
      slot_q        <= slot_d;
      led_marquee_q <= led_marquee_d;
      led_credit1_q <= led_credit1_d;
      led_credit2_q <= led_credit2_d;
      leddata_q     <= leddata_d;
      llc_q         <= llc_d;
      rtc_din_q     <= rtc_din_d;
      rtc_clk_q     <= rtc_clk_d;
      rtc_stb_q     <= rtc_stb_d;
      commit_q      <= commit_d;
    end
  end

  assign P1_OUT      = p1_q;
  assign P2_OUT      = p2_q;
  assign CARD_BANK   = bank_q;
  assign SLOT        = slot_q;
  assign LED_MARQUEE = led_marquee_q;
  assign LED_CREDIT1 = led_credit1_q;
  assign LED_CREDIT2 = led_credit2_q;
  assign RTC_DIN     = rtc_din_q;
  assign RTC_CLK     = rtc_clk_q;
  assign RTC_STB     = rtc_stb_q;
  assign WR_COMMIT   = commit_q;

endmodule

// File: tb/tb_c1_outputs.sv
// Self-checking bench for c1_outputs: directed test-plan writes followed by
// randomized writes, all checked against a behavioural register-bank model.
module tb_c1_outputs;

  localparam int unsigned S = 2;

  logic       CLK_24M = 1'b0;
  logic       nRESET;
  logic       nPORTWEL;
  logic [2:0] M68K_ADDR;
  logic [7:0] M68K_DATA;
  logic [2:0] P1_OUT, P2_OUT, CARD_BANK, SLOT;
  logic [7:0] LED_MARQUEE, LED_CREDIT1, LED_CREDIT2;
  logic       RTC_DIN, RTC_CLK, RTC_STB, WR_COMMIT;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;

  c1_outputs #(.SYNC_STAGES(S)) dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .nPORTWEL(nPORTWEL),
    .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
    .P1_OUT(P1_OUT), .P2_OUT(P2_OUT), .CARD_BANK(CARD_BANK), .SLOT(SLOT),
    .LED_MARQUEE(LED_MARQUEE), .LED_CREDIT1(LED_CREDIT1), .LED_CREDIT2(LED_CREDIT2),
    .RTC_DIN(RTC_DIN), .RTC_CLK(RTC_CLK), .RTC_STB(RTC_STB), .WR_COMMIT(WR_COMMIT)
  );

  always #5 CLK_24M = ~CLK_24M;

  // Counts WR_COMMIT pulses, sampled mid-cycle
  always @(negedge CLK_24M) if (WR_COMMIT === 1'b1) commit_cnt++;

  // Behavioural model of the visible register bank
  logic [2:0] m_p1, m_p2, m_bank, m_slot, m_llc;
  logic [7:0] m_led [3];
  logic [7:0] m_leddata;
  logic       m_din, m_clk, m_stb;

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_bank = 0; m_slot = 0; m_llc = 3'b111;
    m_leddata = 0; m_din = 0; m_clk = 0; m_stb = 0;
    for (int i = 0; i < 3; i++) m_led[i] = 0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    logic [2:0] nl;
    case (a)
      3'd0: begin m_p1 = d[2:0]; m_p2 = d[5:3]; end
      3'd1: m_bank = d[2:0];
      3'd2: m_slot = d[2:0];
      3'd3: begin
        nl = d[5:3];
        for (int i = 0; i < 3; i++)
          if (m_llc[i] && !nl[i]) m_led[i] = m_leddata;
        m_llc = nl;
      end
      3'd4: m_leddata = d;
      3'd5: begin m_din = d[0]; m_clk = d[1]; m_stb = d[2]; end
      default: ;
    endcase
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({P1_OUT, P2_OUT, CARD_BANK, SLOT, LED_MARQUEE, LED_CREDIT1,
                LED_CREDIT2, RTC_DIN, RTC_CLK, RTC_STB});
  endfunction

  function automatic logic [63:0] exp_vec();
    return 64'({m_p1, m_p2, m_bank, m_slot, m_led[0], m_led[1], m_led[2],
                m_din, m_clk, m_stb});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One strobe: low for 'low' cycles (>= S+1), then high for 'high' cycles
  task automatic do_write(input string tag, input logic [2:0] a, input logic [7:0] d,
                          input int low, input int high);
    int c0;
    @(negedge CLK_24M);
    M68K_ADDR = a; M68K_DATA = d; nPORTWEL = 1'b0;
    c0 = commit_cnt;
    for (int i = 1; i <= int'(S); i++) @(negedge CLK_24M);
    check({tag, "_pre_commit"}, 64'(WR_COMMIT), 64'(0));
    check({tag, "_pre_outputs"}, dut_vec(), exp_vec());
    model_write(a, d);
    @(negedge CLK_24M);
    check({tag, "_commit_pulse"}, 64'(WR_COMMIT), 64'(1));
    check({tag, "_outputs"}, dut_vec(), exp_vec());
    for (int i = int'(S) + 2; i <= low; i++) @(negedge CLK_24M);
    nPORTWEL = 1'b1;
    for (int i = 0; i < high; i++) @(negedge CLK_24M);
    check({tag, "_commit_count"}, 64'(commit_cnt - c0), 64'(1));
  endtask

  int c0;
  logic [2:0] ra;
  logic [7:0] rd;

  initial begin
    nRESET = 1'b0; nPORTWEL = 1'b1; M68K_ADDR = 0; M68K_DATA = 0;
    model_reset();
    repeat (3) @(negedge CLK_24M);
    check("reset_outputs", dut_vec(), 64'(0));
    check("reset_commit", 64'(WR_COMMIT), 64'(0));
    nRESET = 1'b1;
    repeat (6) @(negedge CLK_24M);

    do_write("poutput", 3'd0, 8'h2D, 6, 2);
    check("poutput_p1p2", 64'({P1_OUT, P2_OUT}), 64'(6'b101101));

    // Reset asserted in the middle of a strobe, released with strobe still low
    @(negedge CLK_24M);
    M68K_ADDR = 3'd0; M68K_DATA = 8'h3F; nPORTWEL = 1'b0;
    @(negedge CLK_24M);
    #2 nRESET = 1'b0;
    #1;
    model_reset();
    check("midwrite_reset_outputs", dut_vec(), 64'(0));
    check("midwrite_reset_commit", 64'(WR_COMMIT), 64'(0));
    repeat (2) @(negedge CLK_24M);
    c0 = commit_cnt;
    nRESET = 1'b1;
    repeat (10) @(negedge CLK_24M);
    check("low_at_release_no_commit", 64'(commit_cnt - c0), 64'(0));
    check("low_at_release_outputs", dut_vec(), 64'(0));
    nPORTWEL = 1'b1;
    repeat (4) @(negedge CLK_24M);

    // LED latch sequence
    do_write("leddata_a5", 3'd4, 8'hA5, 4, 2);
    do_write("llc_00", 3'd3, 8'h00, 4, 2);
    check("leds_all_a5", 64'({LED_MARQUEE, LED_CREDIT1, LED_CREDIT2}), 64'(24'hA5A5A5));
    do_write("llc_38", 3'd3, 8'h38, 4, 2);
    do_write("leddata_3c", 3'd4, 8'h3C, 4, 2);
    do_write("llc_30", 3'd3, 8'h30, 4, 2);
    check("leds_marquee_only", 64'({LED_MARQUEE, LED_CREDIT1, LED_CREDIT2}), 64'(24'h3CA5A5));

    // Long strobe then back-to-back write after one high cycle
    do_write("long_strobe", 3'd2, 8'h05, 20, 1);
    do_write("b2b_crdbank", 3'd1, 8'h06, 4, 3);
    check("crdbank_110", 64'(CARD_BANK), 64'(3'b110));

    do_write("unused6", 3'd6, 8'hFF, 4, 2);
    do_write("unused7", 3'd7, 8'hFF, 4, 2);

    do_write("rtc_01", 3'd5, 8'h01, 4, 2);
    check("rtc_001", 64'({RTC_STB, RTC_CLK, RTC_DIN}), 64'(3'b001));
    do_write("rtc_03", 3'd5, 8'h03, 4, 2);
    check("rtc_011", 64'({RTC_STB, RTC_CLK, RTC_DIN}), 64'(3'b011));
    do_write("rtc_05", 3'd5, 8'h05, 4, 2);
    check("rtc_101", 64'({RTC_STB, RTC_CLK, RTC_DIN}), 64'(3'b101));

    // Short glitches (to an unused address): at most one commit each
    @(negedge CLK_24M);
    M68K_ADDR = 3'd6; c0 = commit_cnt;
    #3 nPORTWEL = 1'b0;
    #4 nPORTWEL = 1'b1;
    repeat (8) @(negedge CLK_24M);
    check("glitch_across_edge", 64'((commit_cnt - c0) <= 1), 64'(1));
    c0 = commit_cnt;
    #3 nPORTWEL = 1'b0;
    #1 nPORTWEL = 1'b1;
    repeat (8) @(negedge CLK_24M);
    check("glitch_between_edges", 64'((commit_cnt - c0) <= 1), 64'(1));
    check("glitch_outputs", dut_vec(), exp_vec());

    // Randomized writes against the model
    for (int n = 0; n < 40; n++) begin
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      do_write("random", ra, rd, int'($urandom_range(S + 1, 8)), int'($urandom_range(1, 4)));
    end
    check("random_final", dut_vec(), exp_vec());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
